seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised multiplexed seven-segment display driver for DIGITS hex digits sharing one segment bus. It contains an internal scan-rate divider, double-buffered display data with frame-synchronous update, per-digit decimal points, optional leading-zero blanking, an anti-ghosting guard interval and selectable output polarity. It sits between CPU/debug registers and the board's common-anode or common-cathode display pins.

Parameters:
DIGITS, 4, number of digits driven; legal range 1..8.
SCAN_DIV, 8250, clk_in cycles per digit slot; must be >= GUARD+2.
GUARD, 2, cycles at the start of each slot during which all digit selects are inactive; must be >= 1.
SEG_ACTIVE_LOW, 1, 1 = segment outputs are active-low.
DIG_ACTIVE_LOW, 1, 1 = digit selects are active-low.

Ports:
clk_in  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
value  input  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant
dp  input  DIGITS  decimal point per digit
load  input  1  capture strobe for value/dp/lz_en
lz_en  input  1  leading-zero blanking enable, captured with load
seg  output  8  {dp,g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
dig  output  DIGITS  one-hot digit select, polarity set by DIG_ACTIVE_LOW
frame  output  1  one-cycle pulse, high in the cycle the scan index returns to 0

Behaviour:
- Reset (asynchronous, active-low reset_n, clock clk_in): cnt=0, idx=0, shadow=0, active=0 (value, dp, lz_en all zero). seg, dig drive the all-inactive level. frame=0. Reset mid-scan blanks the outputs immediately; after release the scan restarts at digit 0.
- Divider: cnt counts 0..SCAN_DIV-1 and wraps to 0. tick = (cnt==SCAN_DIV-1).
- Scan index: idx advances on tick and wraps from DIGITS-1 to 0. Each slot is exactly SCAN_DIV cycles; a full frame is DIGITS*SCAN_DIV cycles.
- frame: registered. High for one cycle, coincident with the first cycle of idx=0 after a wrap. No frame pulse follows reset release.
- Double buffering:
  - load=1 writes value/dp/lz_en into shadow on that edge.
  - On the wrap edge (tick with idx==DIGITS-1), shadow is copied to active.
  - If load and wrap occur on the same edge, active takes the input port values directly, and shadow also takes them.
  - Display content changes only at frame boundaries; no tearing.
- Decode (nibble from active[idx]), bits gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71
  - seg[7] = active dp[idx].
- Leading-zero blanking: digit i>0 has a..g forced off when lz_en=1 and nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. dp is unaffected by blanking.
- Guard: dig selects digit idx only when cnt >= GUARD; otherwise all digits are inactive.
- Latency: seg and dig are registered functions of (cnt, idx, active), giving one cycle of latency. seg changes only while dig is inactive.
- Polarity is applied at the output register; internal logic is active-high.

Test Plan:
All scenarios use DIGITS=4, SCAN_DIV=8, GUARD=2, both polarities active-low.
1. Reset: hold reset_n=0 -> seg=8'hFF, dig=4'hF, frame=0. After release, the first frame pulse occurs 32 cycles later, then repeats every 32 cycles. Display shows "0000": seg=8'hC0 during each active window.
2. Load value=16'h1234, dp=4'b0000, lz_en=0 -> after the next frame pulse:
   - slot 0: dig=4'b1110, seg=8'h99 ("4").
   - slot 3: dig=4'b0111, seg=8'hF9 ("1").
3. Leading zeros: value=16'h0050, lz_en=1 -> digits 3 and 2 give seg=8'hFF while selected; digit 1 gives 8'h92; digit 0 gives 8'hC0. value=16'h0000 -> only digit 0 is lit (8'hC0). Setting dp[3]=1 while digit 3 is blanked -> seg=8'h7F.
4. Tearing: with 16'h1234 displayed, load 16'hABCD while idx=2 -> digits 2 and 3 still show 2 and 1 until the frame pulse; afterwards slot 0 gives 8'hA1 ("D"). Load on the exact wrap edge -> the new value appears in the next frame's slot 0.
5. Guard: in every slot, dig is all-inactive for exactly 2 cycles and active for 6. seg transitions only in cycles where dig=4'hF.
6. Reset mid-scan: pull reset_n low during slot 2 -> seg=8'hFF and dig=4'hF in the same cycle (asynchronous). After release, scan restarts at digit 0, active data is cleared, and a load issued before reset is lost.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Display driver bus: register-side data/strobe in, pin-side segment/digit drive out.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic                load;
    logic                lz_en;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   dig;
    logic                frame;

    modport master (
        output value, dp, load, lz_en,
        input  seg, dig, frame
    );

    modport slave (
        input  value, dp, load, lz_en,
        output seg, dig, frame
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous double buffering,
// leading-zero blanking and a blanked guard interval at the start of every digit slot.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 8250,
    parameter int GUARD          = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                clk_in,
    input  logic                reset_n,
    seg7_scan_driver_if.slave   bus
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]     CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]     CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_OFF   = DIG_ACTIVE_LOW ? '1 : '0;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                frame_q, frame_d;
    logic [4*DIGITS-1:0] shd_val_q, shd_val_d;
    logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
    logic                shd_lz_q, shd_lz_d;
    logic [4*DIGITS-1:0] act_val_q, act_val_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;
    logic                act_lz_q, act_lz_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;

    logic                tick;
    logic                wrap;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                zero_run;
    logic [DIGITS-1:0]   dig_hot;
    logic [7:0]          seg_act;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        wrap  = tick && (idx_q == IDX_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        frame_d = wrap;

        shd_val_d = bus.load ? bus.value : shd_val_q;
        shd_dp_d  = bus.load ? bus.dp    : shd_dp_q;
        shd_lz_d  = bus.load ? bus.lz_en : shd_lz_q;

        // Taking the shadow's next value lets a load on the wrap edge land in this frame.
        act_val_d = wrap ? shd_val_d : act_val_q;
        act_dp_d  = wrap ? shd_dp_d  : act_dp_q;
        act_lz_d  = wrap ? shd_lz_d  : act_lz_q;
    end

    // Walk from the most significant digit down so zero_run covers digits i..DIGITS-1.
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        dig_hot   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (act_val_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                cur_nib    = act_val_q[4*i +: 4];
                cur_dp     = act_dp_q[i];
                cur_blank  = act_lz_q && zero_run && (i != 0);
                dig_hot[i] = 1'b1;
            end
        end

        seg_act = {cur_dp, cur_blank ? 7'h00 : hex_to_seg(cur_nib)};
        seg_d   = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
        if (cnt_q >= CNT_GUARD) begin
            dig_d = DIG_ACTIVE_LOW ? ~dig_hot : dig_hot;
        end else begin
            dig_d = DIG_OFF;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            frame_q   <= 1'b0;
            shd_val_q <= '0;
            shd_dp_q  <= '0;
            shd_lz_q  <= 1'b0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            act_lz_q  <= 1'b0;
            seg_q     <= SEG_OFF;
            dig_q     <= DIG_OFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            shd_val_q <= shd_val_d;
            shd_dp_q  <= shd_dp_d;
            shd_lz_q  <= shd_lz_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            act_lz_q  <= act_lz_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.dig   = dig_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: the stimulus side predicts each frame's digit
// windows from its own shadow/active model, a monitor pops one entry per lit window.
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int GUARD    = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        logic [7:0] seg;
        logic [3:0] dig;
        int         slot;
    } exp_t;

    logic clk_in;
    logic reset_n;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    exp_t sb [$];

    // Reference model: last loaded content and content currently on display.
    logic [15:0] shd_v, act_v;
    logic [3:0]  shd_d, act_d;
    logic        shd_lz, act_lz;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endfunction

    function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] d,
                                           input logic lz, input int i);
        logic [3:0] nib;
        logic       blank;
        logic [6:0] s;
        nib   = 4'((v >> (4 * i)) & 16'hF);
        blank = lz && (i > 0) && ((v >> (4 * i)) == 16'h0);
        s     = blank ? 7'h00 : SEG_TBL[nib];
        return ~{d[i], s};
    endfunction

    function automatic void push_frame();
        exp_t e;
        for (int i = 0; i < DIGITS; i++) begin
            e.seg  = exp_seg(act_v, act_d, act_lz, i);
            e.dig  = ~(4'b0001 << i);
            e.slot = i;
            sb.push_back(e);
        end
    endfunction

    function automatic logic [15:0] rand_value();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(0, 2) != 0) v = v | (16'($urandom_range(0, 15)) << (4 * i));
        end
        return v;
    endfunction

    task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
        bus.load  = 1'b1;
        bus.value = v;
        bus.dp    = d;
        bus.lz_en = lz;
        shd_v     = v;
        shd_d     = d;
        shd_lz    = lz;
    endtask

    task automatic start_after_reset();
        shd_v = '0; shd_d = '0; shd_lz = 1'b0;
        act_v = '0; act_d = '0; act_lz = 1'b0;
        push_frame();
        reset_n = 1'b1;
    endtask

    // Entered on the negedge of a frame's first cycle (or of reset release); returns on
    // the negedge where the next frame pulse is seen. A load driven at offset k is
    // captured at the edge closing that cycle, so any load in this frame shows next frame.
    task automatic run_frame(input bit directed, input logic [15:0] dv, input logic [3:0] ddp,
                             input logic dlz, input int doff, input int rate);
        int off;
        bit got;
        off = 0;
        got = 1'b0;
        while (!got && off < FRAME + 8) begin
            if (directed && off == doff)
                drive_load(dv, ddp, dlz);
            else if (!directed && off < FRAME &&
                     ($urandom_range(0, 31) < rate || (off == FRAME - 1 && rate > 0 && $urandom_range(0, 3) == 0)))
                drive_load(rand_value(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else
                bus.load = 1'b0;
            @(negedge clk_in);
            off++;
            if (bus.frame) got = 1'b1;
        end
        bus.load = 1'b0;
        chk("frame_period", off, FRAME);
        if (got) begin
            chk("sb_drain", sb.size(), 0);
            sb.delete();
            act_v  = shd_v;
            act_d  = shd_d;
            act_lz = shd_lz;
            push_frame();
        end
    endtask

    // Monitor: one scoreboard pop per lit window, plus guard/width/stability checks.
    bit         prev_act;
    bit         first_win;
    bit         seg_moved;
    int         gap_len;
    int         win_len;
    logic [7:0] prev_seg;

    always @(negedge clk_in) begin
        bit   act;
        exp_t e;
        if (!reset_n) begin
            prev_act  = 1'b0;
            first_win = 1'b1;
            seg_moved = 1'b0;
            gap_len   = 0;
            win_len   = 0;
            prev_seg  = bus.seg;
        end else begin
            act = (bus.dig != 4'hF);
            if (act && !prev_act) begin
                if (!first_win) chk("guard_len", gap_len, GUARD);
                first_win = 1'b0;
                seg_moved = (bus.seg != prev_seg);
                win_len   = 1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: window with dig=%h seg=%h, expected no window", bus.dig, bus.seg);
                end else begin
                    checks--;
                    e = sb.pop_front();
                    chk($sformatf("dig_slot%0d", e.slot), bus.dig, e.dig);
                    chk($sformatf("seg_slot%0d", e.slot), bus.seg, e.seg);
                end
            end else if (act) begin
                win_len++;
                if (bus.seg != prev_seg) seg_moved = 1'b1;
            end else if (prev_act) begin
                chk("win_len", win_len, SCAN_DIV - GUARD);
                chk("seg_stable_while_lit", seg_moved, 0);
                gap_len = 1;
            end else begin
                gap_len++;
            end
            prev_act = act;
            prev_seg = bus.seg;
        end
    end

    initial begin
        reset_n   = 1'b0;
        bus.value = '0;
        bus.dp    = '0;
        bus.load  = 1'b0;
        bus.lz_en = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_seg", bus.seg, 8'hFF);
        chk("rst_dig", bus.dig, 4'hF);
        chk("rst_frame", bus.frame, 0);

        start_after_reset();
        run_frame(1'b1, 16'h1234, 4'b0000, 1'b0, 5, 0);
        run_frame(1'b0, '0, '0, 1'b0, 0, 0);
        run_frame(1'b1, 16'h0050, 4'b0000, 1'b1, 0, 0);
        run_frame(1'b1, 16'h0000, 4'b0000, 1'b1, 10, 0);
        run_frame(1'b1, 16'h0000, 4'b1000, 1'b1, FRAME - 1, 0);
        run_frame(1'b1, 16'h1234, 4'b0000, 1'b0, 20, 0);
        run_frame(1'b1, 16'hABCD, 4'b0000, 1'b0, 2 * SCAN_DIV + 2, 0);
        run_frame(1'b1, 16'h5A0F, 4'b0101, 1'b0, FRAME - 1, 0);
        run_frame(1'b0, '0, '0, 1'b0, 0, 0);
        for (int f = 0; f < 24; f++) run_frame(1'b0, '0, '0, 1'b0, 0, $urandom_range(0, 3));

        // Asynchronous reset while digit 2 is lit; a load made just before is discarded.
        for (int off = 0; off < 2 * SCAN_DIV + 4; off++) begin
            if (off == 2) drive_load(16'h9876, 4'b1111, 1'b0);
            else bus.load = 1'b0;
            @(negedge clk_in);
        end
        bus.load = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_seg", bus.seg, 8'hFF);
        chk("midrst_dig", bus.dig, 4'hF);
        chk("midrst_frame", bus.frame, 0);
        sb.delete();
        repeat (3) @(negedge clk_in);
        start_after_reset();
        run_frame(1'b0, '0, '0, 1'b0, 0, 0);
        run_frame(1'b0, '0, '0, 1'b0, 0, 0);
        for (int f = 0; f < 6; f++) run_frame(1'b0, '0, '0, 1'b0, 0, $urandom_range(1, 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
